// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl: clears the 8-lane input buffer, then streams row_cnt rows from the
// activation SRAM (base_addr upward) into it. Each row is loaded once and held valid
// until the PE array accepts it.
// Optional build macro: STALL_CNT_EN adds stall_cnt, a saturating count of HOLD cycles
// spent waiting for pe_ready.
module input_buffer_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              CLKEXT,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        row_cnt,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              EN_BUF_IN,
    output logic              CLR_BUF_IN,
    output logic              buf_valid,
    input  logic              pe_ready,
    output logic              busy,
`ifdef STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    // WAIT lasts MEM_LAT-1 cycles; lat_cnt runs 0..MEM_LAT-2.
    localparam int unsigned LatW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StWait,
        StLoad,
        StHold,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;

    // State and job registers; reset returns to IDLE from anywhere.
    always_ff @(posedge CLKEXT) begin
        if (RST) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic; job parameters are captured only on an accepted start.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (row_cnt != 8'd0) begin
                        state_d = StClear;
                        base_d  = base_addr;
                        cnt_d   = row_cnt;
                        idx_d   = '0;
                    end else begin
                        // Empty job: report completion without touching the buffer.
                        state_d = StDone;
                    end
                end
            end
            StClear: state_d = StFetch;
            StFetch: begin
                lat_cnt_d = '0;
                state_d   = (MEM_LAT == 1) ? StLoad : StWait;
            end
            StWait: begin
                if (lat_cnt_q == LatLast) begin
                    lat_cnt_d = '0;
                    state_d   = StLoad;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StLoad: state_d = StHold;
            StHold: begin
                // buf_valid is high throughout HOLD, so pe_ready alone completes the handshake.
                if (pe_ready) begin
                    if (idx_q == cnt_q - 8'd1) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs; reset forces everything low except the buffer clear.
    always_comb begin
        mem_rd     = 1'b0;
        mem_addr   = '0;
        EN_BUF_IN  = 1'b0;
        CLR_BUF_IN = RST;
        buf_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!RST) begin
            busy = (state_q != StIdle);
            unique case (state_q)
                StClear: CLR_BUF_IN = 1'b1;
                StFetch: begin
                    mem_rd   = 1'b1;
                    mem_addr = base_q + ADDR_W'(idx_q);
                end
                StLoad:  EN_BUF_IN = 1'b1;
                StHold:  buf_valid = 1'b1;
                StDone:  done = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic        start_acc;
    logic [15:0] stall_q;

    assign start_acc = (state_q == StIdle) && start;

    // Saturating stall counter; value survives DONE until the next accepted start.
    always_ff @(posedge CLKEXT) begin
        if (RST || start_acc) begin
            stall_q <= '0;
        end else if ((state_q == StHold) && !pe_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Self-checking bench for input_buffer_ctrl: cycle tables on a MEM_LAT=1 instance plus a
// latency-tracking sequence on a MEM_LAT=3 instance.
`timescale 1ns/1ps
module tb_input_buffer_ctrl;

    // Output bundle: {mem_rd, mem_addr[9:0], EN_BUF_IN, CLR_BUF_IN, buf_valid, busy, done}
    localparam logic [15:0] OIdle = 16'h0000;
    localparam logic [15:0] OClr  = 16'h000A;
    localparam logic [15:0] OLoad = 16'h0012;
    localparam logic [15:0] OHold = 16'h0006;
    localparam logic [15:0] ODone = 16'h0003;
    localparam logic [15:0] ORst  = 16'h0008;

    typedef struct {
        string       tag;
        logic        rst;
        logic        start;
        logic        pe;
        logic [9:0]  base;
        logic [7:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    logic        CLKEXT = 1'b0;
    logic        RST;
    logic        start, pe_ready;
    logic [9:0]  base_addr;
    logic [7:0]  row_cnt;
    logic        mem_rd, EN_BUF_IN, CLR_BUF_IN, buf_valid, busy, done;
    logic [9:0]  mem_addr;

    logic        start3, pe3;
    logic [9:0]  base3;
    logic [7:0]  cnt3;
    logic        mem_rd3, en3, clr3, valid3, busy3, done3;
    logic [9:0]  mem_addr3;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt3;
`endif

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    logic [9:0]  addr3_q[$];
    int          en_due_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 CLKEXT = ~CLKEXT;

    input_buffer_ctrl #(.ADDR_W(10), .MEM_LAT(1)) u_dut (
`ifdef STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .CLKEXT    (CLKEXT),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .row_cnt   (row_cnt),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .EN_BUF_IN (EN_BUF_IN),
        .CLR_BUF_IN(CLR_BUF_IN),
        .buf_valid (buf_valid),
        .pe_ready  (pe_ready),
        .busy      (busy),
        .done      (done)
    );

    input_buffer_ctrl #(.ADDR_W(10), .MEM_LAT(3)) u_dut3 (
`ifdef STALL_CNT_EN
        .stall_cnt (stall_cnt3),
`endif
        .CLKEXT    (CLKEXT),
        .RST       (RST),
        .start     (start3),
        .base_addr (base3),
        .row_cnt   (cnt3),
        .mem_rd    (mem_rd3),
        .mem_addr  (mem_addr3),
        .EN_BUF_IN (en3),
        .CLR_BUF_IN(clr3),
        .buf_valid (valid3),
        .pe_ready  (pe3),
        .busy      (busy3),
        .done      (done3)
    );

    function automatic logic [15:0] ofetch(input logic [9:0] a);
        return {1'b1, a, 5'b00010};
    endfunction

    function automatic void add(input string tag, input logic r, input logic s, input logic p,
                                input logic [9:0] b, input logic [7:0] c, input logic [15:0] e);
        vec_t v;
        v.tag   = tag;
        v.rst   = r;
        v.start = s;
        v.pe    = p;
        v.base  = b;
        v.cnt   = c;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Drive one table row per cycle; expected bundle queued at drive, popped at negedge.
    task automatic run_vecs();
        vec_t        v;
        logic [15:0] got;
        logic [15:0] e;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge CLKEXT);
            #1;
            RST       = v.rst;
            start     = v.start;
            pe_ready  = v.pe;
            base_addr = v.base;
            row_cnt   = v.cnt;
            exp_q.push_back(v.exp);
            @(negedge CLKEXT);
            got = {mem_rd, mem_addr, EN_BUF_IN, CLR_BUF_IN, buf_valid, busy, done};
            e   = exp_q.pop_front();
            check($sformatf("%s[%0d]", v.tag, i), 32'(got), 32'(e));
        end
        vecs.delete();
    endtask

    initial begin
        int cyc;
        int n_rd;
        int n_en;
        logic done_seen;

        RST = 1'b1; start = 1'b0; pe_ready = 1'b0; base_addr = '0; row_cnt = '0;
        start3 = 1'b0; pe3 = 1'b1; base3 = '0; cnt3 = '0;

        // Reset state
        add("rst", 1, 0, 0, 10'h000, 8'd0, ORst);
        add("rst", 1, 0, 0, 10'h000, 8'd0, ORst);
        add("rst", 0, 0, 0, 10'h000, 8'd0, OIdle);
        // Two-row job; mid-job start and input changes must be ignored
        add("job2", 0, 1, 1, 10'h010, 8'd2, OIdle);
        add("job2", 0, 0, 1, 10'h155, 8'd7, OClr);
        add("job2", 0, 0, 1, 10'h155, 8'd7, ofetch(10'h010));
        add("job2", 0, 1, 1, 10'h155, 8'd7, OLoad);
        add("job2", 0, 0, 1, 10'h155, 8'd7, OHold);
        add("job2", 0, 0, 1, 10'h155, 8'd7, ofetch(10'h011));
        add("job2", 0, 0, 1, 10'h155, 8'd7, OLoad);
        add("job2", 0, 0, 1, 10'h155, 8'd7, OHold);
        add("job2", 0, 0, 1, 10'h155, 8'd7, ODone);
        add("job2", 0, 0, 1, 10'h155, 8'd7, OIdle);
        // Empty job
        add("empty", 0, 1, 0, 10'h3AB, 8'd0, OIdle);
        add("empty", 0, 0, 0, 10'h3AB, 8'd0, ODone);
        add("empty", 0, 0, 0, 10'h3AB, 8'd0, OIdle);
        // Address wrap
        add("wrap", 0, 1, 1, 10'h3FF, 8'd2, OIdle);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OClr);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, ofetch(10'h3FF));
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OLoad);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OHold);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, ofetch(10'h000));
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OLoad);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OHold);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, ODone);
        add("wrap", 0, 0, 1, 10'h000, 8'd0, OIdle);
        // Backpressure: pe_ready high outside HOLD, low for 5 HOLD cycles
        add("bp", 0, 1, 1, 10'h020, 8'd1, OIdle);
        add("bp", 0, 0, 1, 10'h020, 8'd1, OClr);
        add("bp", 0, 0, 1, 10'h020, 8'd1, ofetch(10'h020));
        add("bp", 0, 0, 1, 10'h020, 8'd1, OLoad);
        for (int k = 0; k < 5; k++) add("bp", 0, 0, 0, 10'h020, 8'd1, OHold);
        add("bp", 0, 0, 1, 10'h020, 8'd1, OHold);
        add("bp", 0, 0, 1, 10'h020, 8'd1, ODone);
        add("bp", 0, 0, 1, 10'h020, 8'd1, OIdle);
        run_vecs();
`ifdef STALL_CNT_EN
        check("stall_cnt_bp", 32'(stall_cnt), 32'd5);
`endif

        // Reset mid-job, then a fresh job must start from row 0
        add("midrst", 0, 1, 0, 10'h040, 8'd3, OIdle);
        add("midrst", 0, 0, 0, 10'h040, 8'd3, OClr);
        add("midrst", 0, 0, 0, 10'h040, 8'd3, ofetch(10'h040));
        add("midrst", 0, 0, 0, 10'h040, 8'd3, OLoad);
        add("midrst", 0, 0, 0, 10'h040, 8'd3, OHold);
        add("midrst", 1, 0, 1, 10'h040, 8'd3, ORst);
        add("midrst", 1, 0, 1, 10'h040, 8'd3, ORst);
        add("midrst", 0, 0, 1, 10'h040, 8'd3, OIdle);
        add("midrst", 0, 0, 1, 10'h040, 8'd3, OIdle);
        add("after", 0, 1, 1, 10'h050, 8'd1, OIdle);
        add("after", 0, 0, 1, 10'h050, 8'd1, OClr);
        add("after", 0, 0, 1, 10'h050, 8'd1, ofetch(10'h050));
        add("after", 0, 0, 1, 10'h050, 8'd1, OLoad);
        add("after", 0, 0, 1, 10'h050, 8'd1, OHold);
        add("after", 0, 0, 1, 10'h050, 8'd1, ODone);
        add("after", 0, 0, 1, 10'h050, 8'd1, OIdle);
        run_vecs();
`ifdef STALL_CNT_EN
        check("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif

        // MEM_LAT=3: each EN_BUF_IN exactly 3 cycles after its mem_rd; mid-job start ignored
        addr3_q.push_back(10'h100);
        addr3_q.push_back(10'h101);
        addr3_q.push_back(10'h102);
        @(posedge CLKEXT);
        #1;
        start3 = 1'b1; base3 = 10'h100; cnt3 = 8'd3; pe3 = 1'b1;
        @(posedge CLKEXT);
        #1;
        start3 = 1'b0; base3 = 10'h2AA; cnt3 = 8'd9;
        cyc = 0; n_rd = 0; n_en = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 60) begin
            @(negedge CLKEXT);
            start3 = (cyc == 8);
            if (mem_rd3) begin
                n_rd++;
                en_due_q.push_back(cyc + 3);
                if (addr3_q.size() != 0) check("lat3_addr", 32'(mem_addr3), 32'(addr3_q.pop_front()));
            end
            if (en3) begin
                n_en++;
                if (en_due_q.size() != 0) check("lat3_en_delay", cyc, en_due_q.pop_front());
            end
            if (done3) done_seen = 1'b1;
            cyc++;
        end
        start3 = 1'b0;
        check("lat3_done_seen", 32'(done_seen), 32'd1);
        check("lat3_rd_count", n_rd, 3);
        check("lat3_en_count", n_en, 3);
        check("lat3_en_pending", en_due_q.size(), 0);
        @(negedge CLKEXT);
        check("lat3_idle_after_done", 32'({busy3, done3}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
